// File: rtl/alu_sleep_requester.sv
`default_nettype none
// ============================================================================
// Module   : alu_sleep_requester
// Purpose  : Watches ALU operation traffic and asks the PMU to power the ALU
//            domain down after a programmable run of idle cycles. It follows
//            the PMU isolation/power-switch responses through sleep entry and
//            wake-up, and stalls new operations until the domain is usable.
// Ports    : clk       - rising-edge clock
//            rst       - synchronous reset, active low
//            en        - sleep-request enable (0 = never request sleep)
//            op_valid  - issuer presents an operation (held until accepted)
//            op_ready  - operation accepted when op_valid && op_ready
//            iso_ctrl  - PMU isolation (1 = isolated)
//            psw_ctrl  - PMU power switch (1 = powered)
//            idle      - sleep request to the PMU
//            err       - sticky PMU-timeout flag
//            sleep_cnt - completed sleep entries, saturating
// Revision : 1.0 - initial release
// ============================================================================
module alu_sleep_requester #(
    parameter int IDLE_THRESH = 16,
    parameter int SETTLE      = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        iso_ctrl,
    input  logic        psw_ctrl,
    output logic        idle,
    output logic        err,
    output logic [15:0] sleep_cnt
);

    localparam int c_IDLE_W = $clog2(IDLE_THRESH + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT + 1);
    localparam int c_SET_W  = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_THRESH - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_MAX   = c_TMO_W'(TIMEOUT);
    localparam logic [c_SET_W-1:0]  c_SETTLE    = c_SET_W'(SETTLE);

    localparam logic [1:0] c_ST_ACTIVE    = 2'd0;
    localparam logic [1:0] c_ST_SLEEP_REQ = 2'd1;
    localparam logic [1:0] c_ST_SLEEP     = 2'd2;
    localparam logic [1:0] c_ST_WAKE      = 2'd3;

    logic [1:0]          state_q,      state_d;
    logic [c_IDLE_W-1:0] idle_cnt_q,   idle_cnt_d;
    logic [c_TMO_W-1:0]  tmr_q,        tmr_d;
    logic [c_SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic                resp_seen_q,  resp_seen_d;
    logic                wake_pend_q,  wake_pend_d;
    logic                err_q,        err_d;
    logic [15:0]         sleep_cnt_q,  sleep_cnt_d;
    logic                idle_q,       idle_d;
    logic                op_ready_q,   op_ready_d;

    logic                w_sleep_ack;
    logic                w_wake_ack;
    logic                w_tmo;
    logic [c_TMO_W-1:0]  w_tmr_inc;

    // PMU handshake responses must be seen on both controls in the same cycle.
    assign w_sleep_ack = iso_ctrl && !psw_ctrl;
    assign w_wake_ack  = !iso_ctrl && psw_ctrl;
    // Timeout fires on the cycle that would complete TIMEOUT waiting cycles.
    assign w_tmo       = (tmr_q == c_TMO_LAST);
    assign w_tmr_inc   = (tmr_q == c_TMO_MAX) ? tmr_q : tmr_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        tmr_d        = tmr_q;
        settle_cnt_d = settle_cnt_q;
        resp_seen_d  = resp_seen_q;
        wake_pend_d  = wake_pend_q;
        err_d        = err_q;
        sleep_cnt_d  = sleep_cnt_q;

        case (state_q)
            c_ST_ACTIVE: begin
                // An accepted operation on the final count cycle wins over
                // the sleep request.
                if (!en || op_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == c_IDLE_LAST) begin
                    state_d = c_ST_SLEEP_REQ;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            c_ST_SLEEP_REQ: begin
                if (op_valid) begin
                    wake_pend_d = 1'b1;
                end
                if (w_sleep_ack) begin
                    state_d = c_ST_SLEEP;
                    if (sleep_cnt_q != 16'hFFFF) begin
                        sleep_cnt_d = sleep_cnt_q + 16'd1;
                    end
                end else if (w_tmo) begin
                    err_d   = 1'b1;
                    state_d = c_ST_WAKE;
                end else begin
                    tmr_d = w_tmr_inc;
                end
            end
            c_ST_SLEEP: begin
                if (op_valid || wake_pend_q) begin
                    state_d = c_ST_WAKE;
                end
            end
            default: begin
                // WAKE: once power-up is seen the timeout no longer applies;
                // only the settle count remains.
                if (resp_seen_q) begin
                    if (settle_cnt_q == c_SETTLE) begin
                        state_d = c_ST_ACTIVE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end else if (w_wake_ack) begin
                    resp_seen_d = 1'b1;
                end else if (w_tmo) begin
                    err_d   = 1'b1;
                    state_d = c_ST_ACTIVE;
                end else begin
                    tmr_d = w_tmr_inc;
                end
            end
        endcase

        // Every state entry starts with fresh timers.
        if (state_d != state_q) begin
            idle_cnt_d   = '0;
            tmr_d        = '0;
            settle_cnt_d = '0;
            resp_seen_d  = 1'b0;
        end
        if (state_d == c_ST_WAKE) begin
            wake_pend_d = 1'b0;
        end

        // Outputs are registered from the next state so they move with it.
        idle_d     = (state_d == c_ST_SLEEP_REQ) || (state_d == c_ST_SLEEP);
        op_ready_d = (state_d == c_ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= c_ST_WAKE;
            idle_cnt_q   <= '0;
            tmr_q        <= '0;
            settle_cnt_q <= '0;
            resp_seen_q  <= 1'b0;
            wake_pend_q  <= 1'b0;
            err_q        <= 1'b0;
            sleep_cnt_q  <= 16'd0;
            idle_q       <= 1'b0;
            op_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            tmr_q        <= tmr_d;
            settle_cnt_q <= settle_cnt_d;
            resp_seen_q  <= resp_seen_d;
            wake_pend_q  <= wake_pend_d;
            err_q        <= err_d;
            sleep_cnt_q  <= sleep_cnt_d;
            idle_q       <= idle_d;
            op_ready_q   <= op_ready_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign idle      = idle_q;
    assign err       = err_q;
    assign sleep_cnt = sleep_cnt_q;

endmodule
`default_nettype wire
